hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: op_valid  input  1  decoded instruction present in EX stage.
REQ-004 SHALL provide port: op  input  Oper_t  decoded operation.
REQ-005 SHALL provide port: rs_data  input  32  operand A (GPR[rs]).
REQ-006 SHALL provide port: rt_data  input  32  operand B (GPR[rt]).
REQ-007 SHALL provide port: flush  input  1  pipeline flush (exception/ERET).
REQ-008 SHALL provide port: stall_req  output  1  hold EX and earlier stages.
REQ-009 SHALL provide port: busy  output  1  state != IDLE.
REQ-010 SHALL provide port: done  output  1  one-cycle pulse on HI/LO update by a multiply-class op.
REQ-011 SHALL provide ports: hi, lo  output  32 each  architectural HI/LO registers, registered.

Function
REQ-012 SHALL treat OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU as multiply-class ops; OP_MTHI, OP_MTLO as move ops; all other ops, including OP_MUL, SHALL be ignored.
REQ-013 SHALL implement FSM states IDLE, CALC, WRITE.
REQ-014 IDLE: op_valid and multiply-class op and not flush -> latch magnitudes of rs_data/rt_data (signed ops), product sign, op kind, clear 64-bit accumulator and 5-bit counter, go CALC.
REQ-015 IDLE: op_valid and OP_MTHI (OP_MTLO) and not flush -> hi (lo) <= rs_data at that edge, stay IDLE, no stall, no done.
REQ-016 CALC: one radix-2 shift-add iteration per cycle, LSB-first over 32 multiplier bits; counter wraps 31 -> 0 with transition to WRITE; rs_data/rt_data ignored while in CALC.
REQ-017 WRITE: p = unsigned product, negated mod 2^64 if signed op and operand signs differ; {hi,lo} <= p (MULT/MULTU), {hi,lo}+p (MADD/MADDU), {hi,lo}-p (MSUB/MSUBU), all mod 2^64; done=1 this cycle; go IDLE.
REQ-018 Latency: op sampled at edge E -> CALC at E, WRITE at E+32, hi/lo updated at E+33.
REQ-019 stall_req SHALL be combinational = (IDLE and op_valid and multiply-class op) or CALC; SHALL be 0 in WRITE so the held instruction retires on the same edge HI/LO update, preventing re-issue.
REQ-020 flush=1 at an edge in any state -> IDLE, hi/lo unchanged, no done; flush has priority over op_valid and over WRITE commit.
REQ-021 hi/lo SHALL reflect committed values only; no partial results visible during CALC.

Reset
REQ-022 rst_n low SHALL immediately (no clock) force IDLE, hi=0, lo=0, counter=0, accumulator=0, busy=0, done=0; stall_req then follows REQ-019.
REQ-023 Reset asserted mid-CALC or WRITE SHALL abandon the operation with no HI/LO update.

Verification
REQ-024 MULT rs=0xFFFFFFFE, rt=0x00000003 -> stall_req high exactly 33 cycles, done once, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-025 MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at E+33.
REQ-026 MTHI 5, MTLO 7 (no stall), then MADDU 2,3 -> hi=0x00000005, lo=0x0000000D; from hi=lo=0, MSUB 1,1 -> hi=lo=0xFFFFFFFF.
REQ-027 MULT in progress, flush at 10th CALC cycle -> IDLE next edge, busy=0, hi/lo unchanged, no done pulse.
REQ-028 rst_n low mid-CALC (hi=lo=0x12345678 beforehand) -> without clock edge busy=0, hi=lo=0; after release, new MULT 4,4 -> lo=0x10.
REQ-029 rs_data/rt_data toggled every cycle during CALC of MULTU 6,7 -> lo=0x2A, hi=0.

Source files
------------

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: iterative 32x32 shift-add multiplier with
// accumulate/subtract variants and direct HI/LO moves, stalling the pipeline while busy.
package hilo_mdu_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
        OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
    } Oper_t;
endpackage

module hilo_mdu
    import hilo_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  Oper_t       op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
    typedef enum logic [1:0] {K_MUL, K_ADD, K_SUB} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;

    logic        is_mul, is_signed;
    kind_t       op_kind;
    logic [31:0] mag_a, mag_b;
    logic [63:0] prod, hilo_next;

    always_comb begin
        is_mul    = 1'b0;
        is_signed = 1'b0;
        op_kind   = K_MUL;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_mul = 1'b1; end
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; op_kind = K_ADD; end
            OP_MADDU: begin is_mul = 1'b1; op_kind = K_ADD; end
            OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; op_kind = K_SUB; end
            OP_MSUBU: begin is_mul = 1'b1; op_kind = K_SUB; end
            default:  ;
        endcase
    end

    // Signed ops multiply magnitudes; the sign is reapplied at commit.
    assign mag_a = (is_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign mag_b = (is_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;

        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
        case (kind_q)
            K_ADD:   hilo_next = {hi_q, lo_q} + prod;
            K_SUB:   hilo_next = {hi_q, lo_q} - prod;
            default: hilo_next = prod;
        endcase

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid && is_mul) begin
                        state_d  = CALC;
                        mcand_d  = {32'd0, mag_a};
                        mplier_d = mag_b;
                        neg_d    = is_signed & (rs_data[31] ^ rt_data[31]);
                        kind_d   = op_kind;
                        acc_d    = 64'd0;
                        cnt_d    = 5'd0;
                    end else if (op_valid && op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (op_valid && op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
                CALC: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    {hi_d, lo_d} = hilo_next;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= K_MUL;
            mcand_q  <= 64'd0;
            acc_q    <= 64'd0;
            mplier_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    // WRITE drops the stall so the held instruction retires as HI/LO commit.
    assign stall_req = ((state_q == IDLE) && op_valid && is_mul) || (state_q == CALC);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == WRITE) && !flush;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed and random ops checked against an arithmetic
// HI/LO model, including latency, stall length, flush and async reset behaviour.
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    Oper_t       op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          failures;
    logic [63:0] model_hl;

    hilo_mdu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input Oper_t o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        logic [63:0] p;
        if (o == OP_MULT || o == OP_MADD || o == OP_MSUB)
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else
            p = {32'd0, a} * {32'd0, b};
        case (o)
            OP_MADD, OP_MADDU: return hl + p;
            OP_MSUB, OP_MSUBU: return hl - p;
            default:           return p;
        endcase
    endfunction

    task automatic issue(input Oper_t o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    endtask

    task automatic run_mdu(input Oper_t o, input logic [31:0] a, input logic [31:0] b,
                           input bit toggle);
        logic [63:0] exp_hl;
        int stalls, dones, done_at;
        exp_hl = model(o, a, b, model_hl);
        issue(o, a, b);
        @(negedge clk);
        stalls  = stall_req ? 1 : 0;
        dones   = 0;
        done_at = 0;
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done) begin dones++; done_at = n; end
            if (n == 1) check("busy_calc", 64'(busy), 64'd1);
            if (n == 33) check("hilo_hidden_until_commit", {hi, lo}, model_hl);
            if (toggle) begin rs_data = $urandom; rt_data = $urandom; end
        end
        model_hl = exp_hl;
        $display("op=%s rs=%h rt=%h -> hi=%h lo=%h stalls=%0d done_at=%0d",
                 o.name(), a, b, hi, lo, stalls, done_at);
        check("stall_cycles", 64'(stalls), 64'd33);
        check("done_count", 64'(dones), 64'd1);
        check("done_cycle", 64'(done_at), 64'd33);
        check("hilo_result", {hi, lo}, model_hl);
    endtask

    task automatic move(input Oper_t o, input logic [31:0] v);
        issue(o, v, 32'd0);
        @(negedge clk);
        check("move_no_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        @(negedge clk);
        if (o == OP_MTHI) model_hl[63:32] = v; else model_hl[31:0] = v;
        $display("op=%s rs=%h -> hi=%h lo=%h", o.name(), v, hi, lo);
        check("move_hilo", {hi, lo}, model_hl);
        check("move_busy", 64'(busy), 64'd0);
    endtask

    task automatic flush_run(input int n_flush);
        int dones;
        dones = 0;
        issue(OP_MULT, $urandom, $urandom);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        for (int n = 1; n <= n_flush; n++) begin
            @(negedge clk);
            if (n == n_flush) begin
                flush = 1'b1;
                #1;
            end
            if (done) dones++;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) check("flush_busy", 64'(busy), 64'd0);
            if (done) dones++;
        end
        $display("flush at calc cycle %0d -> hi=%h lo=%h dones=%0d", n_flush, hi, lo, dones);
        check("flush_hilo", {hi, lo}, model_hl);
        check("flush_no_done", 64'(dones), 64'd0);
    endtask

    Oper_t       rnd_ops[8] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                                OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
    logic [31:0] corners[4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    initial begin
        Oper_t       ro;
        logic [31:0] ra, rb;
        checks = 0; failures = 0; model_hl = 64'd0;
        rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP;
        rs_data = 32'd0; rt_data = 32'd0; flush = 1'b0;
        #3;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        #9 rst_n = 1'b1;

        run_mdu(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_mdu(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        move(OP_MTHI, 32'd5);
        move(OP_MTLO, 32'd7);
        run_mdu(OP_MADDU, 32'd2, 32'd3, 1'b0);
        check("maddu_const", {hi, lo}, 64'h0000_0005_0000_000D);
        run_mdu(OP_MULT, 32'd0, 32'd0, 1'b0);
        run_mdu(OP_MSUB, 32'd1, 32'd1, 1'b0);
        check("msub_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // OP_MUL writes a GPR, not HI/LO, so the unit must ignore it.
        issue(OP_MUL, 32'd9, 32'd9);
        @(negedge clk);
        check("mul_no_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        @(negedge clk);
        check("mul_ignored_busy", 64'(busy), 64'd0);
        check("mul_ignored_hilo", {hi, lo}, model_hl);

        flush_run(10);
        flush_run(33);

        run_mdu(OP_MULTU, 32'd6, 32'd7, 1'b1);
        check("toggle_const", {hi, lo}, 64'h0000_0000_0000_002A);

        for (int i = 0; i < 10; i++) begin
            ro = rnd_ops[$urandom_range(7, 0)];
            ra = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(3, 0)] : $urandom;
            rb = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(3, 0)] : $urandom;
            if (ro == OP_MTHI || ro == OP_MTLO) move(ro, ra);
            else run_mdu(ro, ra, rb, 1'b0);
        end

        move(OP_MTHI, 32'h1234_5678);
        move(OP_MTLO, 32'h1234_5678);
        issue(OP_MULT, 32'd11, 32'd13);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_hl = 64'd0;
        $display("async reset mid-calc -> hi=%h lo=%h busy=%0b", hi, lo, busy);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mdu(OP_MULT, 32'd4, 32'd4, 1'b0);
        check("post_rst_const", {hi, lo}, 64'h0000_0000_0000_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
